// File: rtl/board_judge.sv
// Tic-tac-toe board judge: snapshots an 18-bit board on start, scans the nine
// cells and then the eight lines, and reports winner/draw/illegal with a done pulse.
module board_judge (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [17:0] state,
    output logic        busy,
    output logic        done,
    output logic [1:0]  winner,
    output logic [2:0]  win_line,
    output logic        draw,
    output logic        illegal,
    output logic [3:0]  x_count,
    output logic [3:0]  o_count
);
    localparam int unsigned BOARD_W = 18;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned CNT_W   = 4;
    localparam logic [IDX_W-1:0] LAST_CELL = IDX_W'(8);
    localparam logic [IDX_W-1:0] LAST_LINE = IDX_W'(7);
    localparam logic [1:0] CELL_X   = 2'b01;
    localparam logic [1:0] CELL_O   = 2'b10;
    localparam logic [1:0] CELL_BAD = 2'b11;

    typedef enum logic [1:0] {IDLE, CELLS, LINES, REPORT} fsm_e;

    fsm_e               fsm_q;
    logic [BOARD_W-1:0] snap_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   xc_q, oc_q;
    logic               inv_q, xwin_q, owin_q;
    logic [2:0]         cand_q;

    logic               busy_q, done_q, draw_q, illegal_q;
    logic [1:0]         winner_q;
    logic [2:0]         win_line_q;
    logic [CNT_W-1:0]   x_count_q, o_count_q;

    function automatic logic [1:0] cell_at(input logic [BOARD_W-1:0] b, input logic [IDX_W-1:0] k);
        cell_at = b[{k, 1'b0} +: 2];
    endfunction

    // Three cell indices of each line: rows, then columns, then diagonals.
    function automatic logic [11:0] line_cells(input logic [2:0] l);
        case (l)
            3'd0:    line_cells = {4'd0, 4'd1, 4'd2};
            3'd1:    line_cells = {4'd3, 4'd4, 4'd5};
            3'd2:    line_cells = {4'd6, 4'd7, 4'd8};
            3'd3:    line_cells = {4'd0, 4'd3, 4'd6};
            3'd4:    line_cells = {4'd1, 4'd4, 4'd7};
            3'd5:    line_cells = {4'd2, 4'd5, 4'd8};
            3'd6:    line_cells = {4'd0, 4'd4, 4'd8};
            default: line_cells = {4'd2, 4'd4, 4'd6};
        endcase
    endfunction

    logic [1:0]  cur_c, ca_c, cb_c, cc_c;
    logic [11:0] lc_c;
    logic        line_x_c, line_o_c, xwin_c, owin_c, ill_c, draw_c;
    logic [2:0]  cand_c, line_out_c;
    logic [1:0]  winner_c;
    logic [4:0]  xc5_c, oc5_c;

    // Current line match folded into the flags so the verdict includes the last line.
    always_comb begin
        cur_c    = cell_at(snap_q, idx_q);
        lc_c     = line_cells(idx_q[2:0]);
        ca_c     = cell_at(snap_q, lc_c[11:8]);
        cb_c     = cell_at(snap_q, lc_c[7:4]);
        cc_c     = cell_at(snap_q, lc_c[3:0]);
        line_x_c = (fsm_q == LINES) && (ca_c == CELL_X) && (cb_c == CELL_X) && (cc_c == CELL_X);
        line_o_c = (fsm_q == LINES) && (ca_c == CELL_O) && (cb_c == CELL_O) && (cc_c == CELL_O);
        xwin_c   = xwin_q | line_x_c;
        owin_c   = owin_q | line_o_c;
        cand_c   = (!(xwin_q | owin_q) && (line_x_c | line_o_c)) ? idx_q[2:0] : cand_q;
        xc5_c    = {1'b0, xc_q};
        oc5_c    = {1'b0, oc_q};
        ill_c    = inv_q || (xc5_c > oc5_c + 5'd1) || (oc5_c > xc5_c + 5'd1) || (xwin_c && owin_c);
        draw_c   = !ill_c && !xwin_c && !owin_c && (xc5_c + oc5_c == 5'd9);
        winner_c = 2'b00;
        if (!ill_c && xwin_c) begin
            winner_c = CELL_X;
        end else if (!ill_c && owin_c) begin
            winner_c = CELL_O;
        end
        line_out_c = (!ill_c && (xwin_c || owin_c)) ? cand_c : 3'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= IDLE;
            snap_q     <= '0;
            idx_q      <= '0;
            xc_q       <= '0;
            oc_q       <= '0;
            inv_q      <= 1'b0;
            xwin_q     <= 1'b0;
            owin_q     <= 1'b0;
            cand_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            winner_q   <= '0;
            win_line_q <= '0;
            draw_q     <= 1'b0;
            illegal_q  <= 1'b0;
            x_count_q  <= '0;
            o_count_q  <= '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        fsm_q      <= CELLS;
                        snap_q     <= state;
                        idx_q      <= '0;
                        xc_q       <= '0;
                        oc_q       <= '0;
                        inv_q      <= 1'b0;
                        xwin_q     <= 1'b0;
                        owin_q     <= 1'b0;
                        cand_q     <= '0;
                        busy_q     <= 1'b1;
                        winner_q   <= '0;
                        win_line_q <= '0;
                        draw_q     <= 1'b0;
                        illegal_q  <= 1'b0;
                        x_count_q  <= '0;
                        o_count_q  <= '0;
                    end
                end
                CELLS: begin
                    if (cur_c == CELL_X) xc_q <= xc_q + CNT_W'(1);
                    if (cur_c == CELL_O) oc_q <= oc_q + CNT_W'(1);
                    if (cur_c == CELL_BAD) inv_q <= 1'b1;
                    if (idx_q == LAST_CELL) begin
                        fsm_q <= LINES;
                        idx_q <= '0;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                LINES: begin
                    xwin_q <= xwin_c;
                    owin_q <= owin_c;
                    cand_q <= cand_c;
                    if (idx_q == LAST_LINE) begin
                        fsm_q      <= REPORT;
                        idx_q      <= '0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        winner_q   <= winner_c;
                        win_line_q <= line_out_c;
                        draw_q     <= draw_c;
                        illegal_q  <= ill_c;
                        x_count_q  <= xc_q;
                        o_count_q  <= oc_q;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                REPORT: begin
                    done_q <= 1'b0;
                    fsm_q  <= IDLE;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign winner   = winner_q;
    assign win_line = win_line_q;
    assign draw     = draw_q;
    assign illegal  = illegal_q;
    assign x_count  = x_count_q;
    assign o_count  = o_count_q;
endmodule

// File: doc/board_judge.md
# board_judge

Sequential evaluator that reads the 18-bit tic-tac-toe board word produced by the move writer and judges it. Each cell is 2 bits: 00 empty, 01 player X, 10 player O, 11 invalid. Cell k occupies bits [2k+1:2k], for k = 0..8 in row-major order. On a start request the block snapshots the board, scans cells and then lines over a fixed number of cycles, and reports the outcome with a one-cycle done pulse. The game controller uses it after every move to decide whether play continues.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  evaluation request; sampled only in IDLE.
- state  in  18  board word, 2 bits per cell; sampled only on the edge that accepts start.
- busy  out  1  high while scanning.
- done  out  1  one-cycle pulse when results become valid.
- winner  out  2  00 none, 01 X, 10 O; never 11.
- win_line  out  3  index of the winning line; 0 when winner = 00.
- draw  out  1  board full, no winner, legal.
- illegal  out  1  board is inconsistent.
- x_count  out  4  number of 01 cells (0..9).
- o_count  out  4  number of 10 cells (0..9).

## Operation
- **FSM states:** IDLE, CELLS, LINES, REPORT.
- **IDLE:** when start=1, latch state into an internal snapshot, clear the counters and flags, set idx=0, and go to CELLS. When start=0, stay.
- **CELLS (9 cycles, idx 0..8):** examine snapshot cell idx.
  - 01: increment the X count.
  - 10: increment the O count.
  - 11: set the invalid-cell flag.
  - After idx 8, go to LINES with idx=0.
- **LINES (8 cycles, idx 0..7):** fixed line table.
  - Rows: 0 = cells {0,1,2}, 1 = {3,4,5}, 2 = {6,7,8}.
  - Columns: 3 = {0,3,6}, 4 = {1,4,7}, 5 = {2,5,8}.
  - Diagonals: 6 = {0,4,8}, 7 = {2,4,6}.
  - A line is won when all three cells are equal and equal to 01 or 10. Set the X-win or O-win flag accordingly.
  - The first winning line in index order is recorded as the candidate line; later matches do not change it.
  - After idx 7, go to REPORT.
- **REPORT (1 cycle):** done=1 and all outputs update in this cycle; then go to IDLE.
  - illegal = invalid-cell flag OR |x_count − o_count| > 1 OR (X-win AND O-win).
  - If illegal: winner=00, win_line=0, draw=0.
  - Otherwise: winner = the winning player's code; win_line = the candidate line; draw = (no win AND x_count + o_count = 9).
  - x_count and o_count are always reported, even when illegal.
- **Result hold:** results stay stable from REPORT until the next accepted start. They clear to 0 on the edge that accepts that start.
- **Ignored inputs:** start is ignored in CELLS, LINES and REPORT; it is not queued. Changes on state after acceptance have no effect.
- **Counter width:** the counters saturate naturally at 9 in 4 bits. The difference check uses 5-bit signed arithmetic, or a compare of the larger count against the smaller + 1.

## Timing
- **Reset:** rst=1 forces IDLE. Next cycle outputs are busy=0, done=0, winner=00, win_line=0, draw=0, illegal=0, x_count=0, o_count=0.
- **Reset priority:** rst beats start on the same edge. Reset mid-scan aborts with no done pulse.
- **Latency:** with start accepted at edge t:
  - busy=1 during the 17 cycles after t (9 in CELLS + 8 in LINES).
  - done=1 and results valid in the 18th cycle after t, with busy=0.
  - Back in IDLE the cycle after that.
- **Minimum spacing:** back-to-back evaluations start every 19 cycles. start held high continuously is re-accepted in the first IDLE cycle after REPORT.
- **Overlap:** busy and done are never high together.

## Test plan
- **Empty board:** state=0, pulse start → done exactly 18 cycles later; winner=00, draw=0, illegal=0, counts 0/0; busy high for exactly 17 cycles.
- **X row win:** cells 0,1,2=01 and cells 3,4=10 → winner=01, win_line=0, x_count=3, o_count=2, draw=0.
- **Double-line match:** X wins both column 3 and diagonal 6 (cells 0,3,6,4,8=01; cells 1,2,5,7=10) → winner=01, win_line=3 (first match), draw=0, illegal=0.
- **Draw:** full board X,O,X / X,O,O / O,X,X → winner=00, draw=1, x_count=5, o_count=4.
- **Illegal boards:**
  - Cell 4=11 → illegal=1, winner=00.
  - X row 0 plus O row 1 → illegal=1.
  - Four X and one O → illegal=1, x_count=4, o_count=1.
- **Control:**
  - Change state and pulse start during busy → result reflects the original snapshot; only one done pulse.
  - Assert rst at cycle 10 of a scan → no done; all outputs 0 next cycle; a new start then completes normally.
